// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
// Shares the RTC multiplexed address/data bus between a write port (user
// time/date edits) and a read port (periodic refresh). Each grant runs one
// complete bus cycle: ADDR -> GAP -> DATA -> RECOV -> ACK -> IDLE.
//
// Ports:
//   clock, reset          system clock, asynchronous active-low reset
//   req_w/addr_w/wdata_w  write request (held until ack_w), address, data
//   ack_w                 one-cycle write-done pulse
//   req_r/addr_r          read request (held until ack_r), address
//   ack_r                 one-cycle read-done pulse
//   rdata                 data of the last completed read
//   busy                  high in every state except IDLE
//   ADo/CSo/RDo/WRo       active-low RTC strobes
//   AdressDatao/_oe/i     bidirectional pad: output data, output enable, input
//
// Configuration macro:
//   RTC_ARB_WRPRIO_EN     when defined, the write port always wins a tie
//                         (read may starve); otherwise ties are round-robin.

module rtc_bus_arbiter #(
    parameter int T_ADDR   = 4,
    parameter int T_HOLD   = 2,
    parameter int T_STROBE = 8,
    parameter int T_IDLE   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_w,
    input  logic [7:0] addr_w,
    input  logic [7:0] wdata_w,
    output logic       ack_w,
    input  logic       req_r,
    input  logic [7:0] addr_r,
    output logic       ack_r,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       ADo,
    output logic       CSo,
    output logic       RDo,
    output logic       WRo,
    output logic [7:0] AdressDatao,
    output logic       AdressData_oe,
    input  logic [7:0] AdressDatai
);

    // Phase lengths must fit the 8-bit down-counter and be non-zero.
    if (T_ADDR < 1 || T_ADDR > 255) begin : g_bad_t_addr
        $error("rtc_bus_arbiter: T_ADDR must be in 1..255");
    end
    if (T_HOLD < 1 || T_HOLD > 255) begin : g_bad_t_hold
        $error("rtc_bus_arbiter: T_HOLD must be in 1..255");
    end
    if (T_STROBE < 1 || T_STROBE > 255) begin : g_bad_t_strobe
        $error("rtc_bus_arbiter: T_STROBE must be in 1..255");
    end
    if (T_IDLE < 1 || T_IDLE > 255) begin : g_bad_t_idle
        $error("rtc_bus_arbiter: T_IDLE must be in 1..255");
    end

    // The counter is loaded with length-1 on phase entry and the phase ends
    // on the edge where it reads zero, so each phase lasts exactly T cycles.
    localparam logic [7:0] LOAD_ADDR   = 8'(T_ADDR - 1);
    localparam logic [7:0] LOAD_HOLD   = 8'(T_HOLD - 1);
    localparam logic [7:0] LOAD_STROBE = 8'(T_STROBE - 1);
    localparam logic [7:0] LOAD_IDLE   = 8'(T_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP,
        DATA,
        RECOV,
        ACK
    } state_t;

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       grant_w, grant_r;
    logic       dir_write;
    logic       last_grant_write;
    logic [7:0] addr_q, wdata_q;

    // Grant decision, only meaningful in IDLE. A request that drops before
    // IDLE samples it simply never produces a grant.
    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (state == IDLE) begin
`ifdef RTC_ARB_WRPRIO_EN
            grant_w = req_w;
            grant_r = req_r & ~req_w;
`else
            if (req_w && req_r) begin
                grant_w = ~last_grant_write;
                grant_r = last_grant_write;
            end else begin
                grant_w = req_w;
                grant_r = req_r;
            end
`endif
        end
    end

    // Next-state, counter reload and Moore outputs. Outputs decode straight
    // from the state so an asynchronous reset releases the bus immediately.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        ADo           = 1'b1;
        CSo           = 1'b1;
        RDo           = 1'b1;
        WRo           = 1'b1;
        AdressDatao   = 8'h00;
        AdressData_oe = 1'b0;
        ack_w         = 1'b0;
        ack_r         = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_w || grant_r) begin
                    state_next = ADDR;
                    cnt_next   = LOAD_ADDR;
                end
            end
            ADDR: begin
                CSo           = 1'b0;
                ADo           = 1'b0;
                WRo           = 1'b0;
                AdressData_oe = 1'b1;
                AdressDatao   = addr_q;
                if (cnt == 8'd0) begin
                    state_next = GAP;
                    cnt_next   = LOAD_HOLD;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            GAP: begin
                CSo           = 1'b0;
                AdressData_oe = 1'b1;
                AdressDatao   = addr_q;
                if (cnt == 8'd0) begin
                    state_next = DATA;
                    cnt_next   = LOAD_STROBE;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            DATA: begin
                CSo = 1'b0;
                if (dir_write) begin
                    WRo           = 1'b0;
                    AdressData_oe = 1'b1;
                    AdressDatao   = wdata_q;
                end else begin
                    RDo = 1'b0;
                end
                if (cnt == 8'd0) begin
                    state_next = RECOV;
                    cnt_next   = LOAD_IDLE;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            RECOV: begin
                if (cnt == 8'd0) begin
                    state_next = ACK;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            ACK: begin
                ack_w      = dir_write;
                ack_r      = ~dir_write;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // State and phase counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Transaction latch at grant time (requester inputs are ignored after
    // this) and read-data capture on the edge that ends the DATA phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_write        <= 1'b0;
            addr_q           <= 8'h00;
            wdata_q          <= 8'h00;
            last_grant_write <= 1'b0;
            rdata            <= 8'h00;
        end else begin
            if (grant_w || grant_r) begin
                dir_write        <= grant_w;
                addr_q           <= grant_w ? addr_w : addr_r;
                wdata_q          <= wdata_w;
                last_grant_write <= grant_w;
            end
            if (state == DATA && cnt == 8'd0 && !dir_write) begin
                rdata <= AdressDatai;
            end
        end
    end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Shares the RTC multiplexed address/data bus between two requesters: a write port (user time/date edits) and a read port (periodic refresh).
- Arbitrates between the ports and sequences one complete bus cycle per grant: address phase, then data phase.
- Drives the ADo/CSo/RDo/WRo strobes and the AdressData pad.
- Sits between the controller FSMs and the RTC pins.

Parameters:
- T_ADDR, 4, address-phase length in clock cycles (1..255)
- T_HOLD, 2, gap between address phase and data phase in cycles (1..255)
- T_STROBE, 8, RD/WR strobe length in cycles (1..255)
- T_IDLE, 2, recovery time after strobe in cycles (1..255)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_w  in  1  write request, held until ack_w
- addr_w  in  8  write register address
- wdata_w  in  8  write data
- ack_w  out  1  one-cycle write-done pulse
- req_r  in  1  read request, held until ack_r
- addr_r  in  8  read register address
- ack_r  out  1  one-cycle read-done pulse
- rdata  out  8  last read data
- busy  out  1  high in every state except IDLE
- ADo  out  1  address strobe, active-low
- CSo  out  1  chip select, active-low
- RDo  out  1  read strobe, active-low
- WRo  out  1  write strobe, active-low
- AdressDatao  out  8  pad output data
- AdressData_oe  out  1  pad output enable
- AdressDatai  in  8  pad input data

Behaviour:
- Reset (asynchronous, active-low):
  - ADo=CSo=RDo=WRo=1, AdressDatao=0, AdressData_oe=0.
  - ack_w=ack_r=0, rdata=0, busy=0.
  - State=IDLE, last_grant=READ.
  - Reset mid-cycle aborts the transaction immediately; no ack is issued.
- States: IDLE, ADDR, GAP, DATA, RECOV, ACK. One 8-bit down-counter is loaded on each phase entry.
- IDLE:
  - Samples req_w/req_r on each edge.
  - On a grant, latches direction, address and data into internal registers, then goes to ADDR.
  - Requester inputs are ignored after the latch.
- Arbitration:
  - Single request: grant it.
  - Both requests: round-robin; grant the port not in last_grant, then update last_grant.
  - A req dropped before it is granted is discarded without an ack.
- ADDR, T_ADDR cycles: CSo=0, ADo=0, WRo=0, oe=1, AdressDatao=address.
- GAP, T_HOLD cycles: CSo=0, ADo=1, WRo=1, RDo=1, oe=1, address held.
- DATA, T_STROBE cycles: CSo=0, ADo=1.
  - Write: WRo=0, oe=1, AdressDatao=wdata.
  - Read: RDo=0, oe=0.
  - rdata captures AdressDatai on the edge that ends DATA. rdata holds until the next read completes and is unchanged by writes.
- RECOV, T_IDLE cycles: all strobes 1, oe=0, AdressDatao=0.
- ACK, 1 cycle:
  - ack_w or ack_r=1, matching the granted port.
  - No arbitration in ACK; next state is IDLE.
  - The requester must drop req, or may keep it high for a new transaction sampled in IDLE.
- Latency: req sampled at edge E0 → ack is high in the cycle after edge E0+T_ADDR+T_HOLD+T_STROBE+T_IDLE (E0+16 with defaults).
- Back-to-back: minimum spacing between consecutive ADDR entries is the cycle total plus 2 (ACK + IDLE).
- Invariants:
  - RDo and WRo are never low at the same time.
  - oe=0 whenever RDo=0.
  - A granted transaction always completes unless reset occurs.
- Out-of-range parameters (0 or >255) are illegal; an elaboration-time $error is required.

Optional Feature:
- Macro: RTC_ARB_WRPRIO_EN
- Defined: strict write priority. With both requests pending in IDLE, the write port always wins; last_grant is still updated but ignored. Read may starve while req_w stays high.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single write (req_w=1, addr_w=0x21, wdata_w=0x45, defaults):
  - AdressDatao=0x21 with ADo=0 for 4 cycles, then 2-cycle gap, then WRo=0 with 0x45 for 8 cycles.
  - ack_w high exactly 1 cycle, 16 cycles after the sample edge. RDo stays 1 throughout.
- Single read (addr_r=0x22, pad drives 0x59 during DATA):
  - RDo=0 for 8 cycles with oe=0.
  - rdata=0x59 at ack_r. rdata is still 0x59 after a subsequent write.
- Simultaneous req_w and req_r held high for 4 transactions:
  - Grants alternate W,R,W,R (first tie goes to W because last_grant=READ at reset).
  - Each ack matches its port.
- Reset asserted during DATA of a write:
  - Strobes return to 1 and oe=0 without waiting for a clock.
  - No ack_w is issued. After release, a new req_r completes normally.
- req_r pulsed for 1 cycle while a write is in progress:
  - The read is never granted and ack_r stays 0.
  - busy drops in IDLE after the write's ACK.
- With RTC_ARB_WRPRIO_EN defined, both requests held high for 3 transactions:
  - All three grants go to W. ack_r stays 0 until req_w drops, then the read completes.
